serializer_gearbox: RTL and testbench



---
 rtl/serializer_gearbox.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_serializer_gearbox.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serializer_gearbox.sv
// serializer_gearbox: buffers variable-length MSB-aligned words and re-slices them into VAL_W-bit values.
// Define SERIALIZER_PROTO_CHECK_EN to add the sticky proto_err protocol checker output.
module serializer_gearbox #(
    parameter int WORD_W     = 38,
    parameter int VAL_W      = 7,
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         packet_in_progress,
    input  logic                         new_word_a,
    output logic                         word_rdy,
    input  logic                         first_word_a,
    input  logic                         last_word_a,
    input  logic [$clog2(WORD_W+1)-1:0]  num_bits_a,
    input  logic [WORD_W-1:0]            word_a,
    output logic [VAL_W-1:0]             data_out,
    output logic                         valid_out,
    input  logic                         out_rdy,
    output logic                         first_value,
    output logic                         last_value,
    output logic                         new_word_s,
    output logic [CNT_W-1:0]             value_counter
`ifdef SERIALIZER_PROTO_CHECK_EN
    ,
    output logic                         proto_err
`endif
);

    localparam int NB_W  = $clog2(WORD_W + 1);
    localparam int ACC_W = WORD_W + VAL_W - 1;
    localparam int R_W   = $clog2(ACC_W + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [R_W-1:0]   VAL_R  = R_W'(VAL_W);
    localparam logic [NB_W-1:0]  WORD_N = NB_W'(WORD_W);
    localparam logic [OCC_W-1:0] FULL_N = OCC_W'(FIFO_DEPTH);

    typedef struct packed {
        logic [WORD_W-1:0] word;
        logic [NB_W-1:0]   nb;
        logic              first;
        logic              last;
    } entry_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [R_W-1:0]    r_q, r_d;
    logic              first_pend_q, first_pend_d;
    logic              last_popped_q, last_popped_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    entry_t            fifo_q [FIFO_DEPTH];
    entry_t            fifo_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  occ_q, occ_d;

    entry_t            head;
    logic              fifo_empty;
    logic              wr_en;
    logic              pop;
    logic              clear;
    logic              xfer;
    logic [NB_W-1:0]   nb_eff;
    logic [WORD_W-1:0] word_mask;
    logic [ACC_W-1:0]  ext;
    logic [R_W-1:0]    r_after;

    assign word_rdy      = (occ_q != FULL_N);
    assign wr_en         = new_word_a && word_rdy;
    assign fifo_empty    = (occ_q == '0);
    assign head          = fifo_q[rd_ptr_q];
    assign data_out      = acc_q[ACC_W-1 -: VAL_W];
    assign first_value   = valid_out && first_pend_q;
    assign new_word_s    = pop;
    assign value_counter = cnt_q;

    // Out-of-range lengths are clamped so a bad word cannot corrupt the residue count.
    always_comb begin
        nb_eff    = (head.nb > WORD_N) ? WORD_N : head.nb;
        word_mask = ~({WORD_W{1'b1}} >> nb_eff);
        ext       = {head.word & word_mask, {(VAL_W-1){1'b0}}};
    end

    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        r_d           = r_q;
        first_pend_d  = first_pend_q;
        last_popped_d = last_popped_q;
        cnt_d         = cnt_q;
        pop           = 1'b0;
        clear         = 1'b0;
        xfer          = 1'b0;
        valid_out     = 1'b0;
        last_value    = 1'b0;
        r_after       = r_q;

        case (state_q)
            IDLE: begin
                // A word being written this cycle is enough to start, saving a cycle of latency.
                if (packet_in_progress && (!fifo_empty || wr_en)) begin
                    state_d       = LOAD;
                    first_pend_d  = 1'b1;
                    last_popped_d = 1'b0;
                end
            end
            LOAD: begin
                if (!fifo_empty) begin
                    pop           = 1'b1;
                    acc_d         = acc_q | (ext >> r_q);
                    r_d           = r_q + R_W'(nb_eff);
                    last_popped_d = head.last;
                    state_d       = SHIFT;
                end
            end
            SHIFT: begin
                valid_out = (r_q >= VAL_R);
                xfer      = valid_out && out_rdy;
                r_after   = xfer ? (r_q - VAL_R) : r_q;
                // Also flag the value that empties the residue when only a zero-length last word remains.
                last_value = valid_out && (r_q == VAL_R) &&
                             (last_popped_q ||
                              (!fifo_empty && head.last && (nb_eff == '0)));
                if (xfer) begin
                    acc_d = acc_q << VAL_W;
                    r_d   = r_after;
                end
                if (r_after < VAL_R) begin
                    if (!last_popped_q) begin
                        state_d = LOAD;
                    end else if (r_after != '0) begin
                        state_d = FLUSH;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            FLUSH: begin
                valid_out  = 1'b1;
                last_value = 1'b1;
                xfer       = out_rdy;
                if (xfer) begin
                    acc_d   = '0;
                    r_d     = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!packet_in_progress) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (xfer) begin
            first_pend_d = 1'b0;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // Abort: packet_in_progress dropped mid-packet discards everything buffered.
        if (!packet_in_progress && (state_q inside {LOAD, SHIFT, FLUSH})) begin
            state_d       = IDLE;
            acc_d         = '0;
            r_d           = '0;
            cnt_d         = '0;
            first_pend_d  = 1'b0;
            last_popped_d = 1'b0;
            pop           = 1'b0;
            clear         = 1'b1;
        end
    end

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (wr_en) begin
                fifo_d[wr_ptr_q] = '{word: word_a, nb: num_bits_a,
                                     first: first_word_a, last: last_word_a};
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({wr_en, pop})
                2'b10:   occ_d = occ_q + OCC_W'(1);
                2'b01:   occ_d = occ_q - OCC_W'(1);
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            acc_q         <= '0;
            r_q           <= '0;
            first_pend_q  <= 1'b0;
            last_popped_q <= 1'b0;
            cnt_q         <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            occ_q         <= '0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            r_q           <= r_d;
            first_pend_q  <= first_pend_d;
            last_popped_q <= last_popped_d;
            cnt_q         <= cnt_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            occ_q         <= occ_d;
        end
    end

    // Buffer storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

`ifdef SERIALIZER_PROTO_CHECK_EN
    logic proto_err_q, proto_err_d;
    logic expect_first_q, expect_first_d;

    always_comb begin
        proto_err_d    = proto_err_q;
        expect_first_d = expect_first_q;
        if (state_q == IDLE && state_d == LOAD) begin
            expect_first_d = 1'b1;
        end
        if (pop) begin
            if (head.first != expect_first_q) begin
                proto_err_d = 1'b1;
            end
            expect_first_d = 1'b0;
        end
        if (new_word_a && (num_bits_a > WORD_N)) begin
            proto_err_d = 1'b1;
        end
        if (new_word_a && !word_rdy) begin
            proto_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            proto_err_q    <= 1'b0;
            expect_first_q <= 1'b0;
        end else begin
            proto_err_q    <= proto_err_d;
            expect_first_q <= expect_first_d;
        end
    end

    assign proto_err = proto_err_q;
`else
    logic unused_first;
    assign unused_first = head.first;
`endif

endmodule

// File: tb/tb_serializer_gearbox.sv
// Scoreboard bench for serializer_gearbox: a bit-level model of each packet feeds an expected-value queue
// that is drained as the DUT transfers values.
`timescale 1ns/1ps
module tb_serializer_gearbox;

    localparam int WORD_W     = 38;
    localparam int VAL_W      = 7;
    localparam int FIFO_DEPTH = 2;
    localparam int CNT_W      = 16;
    localparam int NB_W       = $clog2(WORD_W + 1);

    logic              clk;
    logic              rst;
    logic              packet_in_progress;
    logic              new_word_a;
    logic              word_rdy;
    logic              first_word_a;
    logic              last_word_a;
    logic [NB_W-1:0]   num_bits_a;
    logic [WORD_W-1:0] word_a;
    logic [VAL_W-1:0]  data_out;
    logic              valid_out;
    logic              out_rdy;
    logic              first_value;
    logic              last_value;
    logic              new_word_s;
    logic [CNT_W-1:0]  value_counter;
`ifdef SERIALIZER_PROTO_CHECK_EN
    logic              proto_err;
`endif

    serializer_gearbox #(
        .WORD_W(WORD_W), .VAL_W(VAL_W), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .packet_in_progress(packet_in_progress),
        .new_word_a(new_word_a), .word_rdy(word_rdy), .first_word_a(first_word_a),
        .last_word_a(last_word_a), .num_bits_a(num_bits_a), .word_a(word_a),
        .data_out(data_out), .valid_out(valid_out), .out_rdy(out_rdy),
        .first_value(first_value), .last_value(last_value), .new_word_s(new_word_s),
        .value_counter(value_counter)
`ifdef SERIALIZER_PROTO_CHECK_EN
        , .proto_err(proto_err)
`endif
    );

    typedef struct packed {
        logic [VAL_W-1:0] data;
        logic             first;
        logic             last;
    } exp_t;

    exp_t              exp_q[$];
    exp_t              mon_e;
    logic [WORD_W-1:0] pw_data[$];
    int                pw_nb[$];
    logic              pw_first[$];
    logic              pw_last[$];
    int                exp_nvals;

    int   n_chk;
    int   n_fail;
    int   cyc;
    int   wr_cyc;
    int   n_pop;
    int   xfer_cnt;
    int   last_seen;
    int   rdy_mode;
    int   rdy_phase;
    bit   hold_chk_en;
    bit   held;
    logic [VAL_W-1:0] held_data;
    logic held_first;
    logic held_last;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: concatenate valid bits of every word, slice MSB-first, zero-pad the tail.
    task automatic model_packet();
        logic bits[$];
        logic [VAL_W-1:0] v;
        exp_t e;
        bits.delete();
        for (int i = 0; i < pw_data.size(); i++) begin
            for (int b = 0; b < pw_nb[i]; b++) begin
                bits.push_back(pw_data[i][WORD_W-1-b]);
            end
        end
        exp_nvals = (bits.size() + VAL_W - 1) / VAL_W;
        for (int k = 0; k < exp_nvals; k++) begin
            v = '0;
            for (int b = 0; b < VAL_W; b++) begin
                v = {v[VAL_W-2:0], ((k*VAL_W + b) < bits.size()) ? bits[k*VAL_W + b] : 1'b0};
            end
            e.data  = v;
            e.first = (k == 0);
            e.last  = (k == exp_nvals - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic clear_words();
        pw_data.delete();
        pw_nb.delete();
        pw_first.delete();
        pw_last.delete();
    endtask

    task automatic add_word(input logic [WORD_W-1:0] d, input int nb, input logic f, input logic l);
        pw_data.push_back(d);
        pw_nb.push_back(nb);
        pw_first.push_back(f);
        pw_last.push_back(l);
    endtask

    task automatic load_scn1();
        clear_words();
        add_word({32'hF00CC05A, 6'd0}, 32, 1'b1, 1'b1);
    endtask

    task automatic write_word(input logic [WORD_W-1:0] d, input int nb, input logic f,
                              input logic l, input bit must, output bit accepted);
        new_word_a   = 1'b1;
        word_a       = d;
        num_bits_a   = NB_W'(nb);
        first_word_a = f;
        last_word_a  = l;
        accepted     = 1'b0;
        for (int k = 0; k < 50; k++) begin
            accepted = word_rdy;
            wr_cyc   = cyc;
            tick();
            if (accepted || !must) break;
        end
        new_word_a = 1'b0;
        if (must) check_eq("write_accept", 64'(accepted), 64'd1);
    endtask

    task automatic write_all();
        bit acc;
        for (int i = 0; i < pw_data.size(); i++) begin
            write_word(pw_data[i], pw_nb[i], pw_first[i], pw_last[i], 1'b1, acc);
        end
    endtask

    task automatic drain_and_close(input string tag, input int n_words);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 400) begin
            tick();
            k++;
        end
        check_eq({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
        check_eq({tag, "_count"}, 64'(value_counter), 64'(exp_nvals));
        check_eq({tag, "_valid_low"}, 64'(valid_out), 64'd0);
        check_eq({tag, "_last_seen"}, 64'(last_seen), 64'd1);
        check_eq({tag, "_pops"}, 64'(n_pop), 64'(n_words));
        packet_in_progress = 1'b0;
        tick();
        check_eq({tag, "_count_clr"}, 64'(value_counter), 64'd0);
        check_eq({tag, "_word_rdy"}, 64'(word_rdy), 64'd1);
    endtask

    task automatic start_packet(input int mode);
        exp_q.delete();
        model_packet();
        rdy_phase = 0;
        rdy_mode  = mode;
        n_pop     = 0;
        xfer_cnt  = 0;
        last_seen = 0;
        packet_in_progress = 1'b1;
    endtask

    initial begin
        out_rdy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_rdy = 1'b1;
                1: begin
                    out_rdy = (rdy_phase % 3 == 0);
                    rdy_phase++;
                end
                default: out_rdy = 1'b0;
            endcase
        end
    end

    // Outputs are sampled mid-cycle; a transfer seen here completes at the next rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (new_word_s) n_pop++;
            if (hold_chk_en && held) begin
                check_eq("hold_valid", 64'(valid_out), 64'd1);
                check_eq("hold_data", 64'(data_out), 64'(held_data));
                check_eq("hold_first", 64'(first_value), 64'(held_first));
                check_eq("hold_last", 64'(last_value), 64'(held_last));
            end
            held       = valid_out && !out_rdy;
            held_data  = data_out;
            held_first = first_value;
            held_last  = last_value;
            if (valid_out && out_rdy) begin
                xfer_cnt++;
                if (last_value) last_seen++;
                if (exp_q.size() == 0) begin
                    check_eq("spurious_value", 64'(exp_q.size()), 64'd1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_eq("value_data", 64'(data_out), 64'(mon_e.data));
                    check_eq("value_first", 64'(first_value), 64'(mon_e.first));
                    check_eq("value_last", 64'(last_value), 64'(mon_e.last));
                end
            end
        end else begin
            held = 1'b0;
        end
    end

    initial begin
        bit a1, a2, a3;
        int k;
        n_chk = 0; n_fail = 0; cyc = 0; n_pop = 0; xfer_cnt = 0; last_seen = 0;
        rdy_mode = 2; rdy_phase = 0; hold_chk_en = 1'b0; held = 1'b0;
        rst = 1'b1; packet_in_progress = 1'b0; new_word_a = 1'b0;
        first_word_a = 1'b0; last_word_a = 1'b0; num_bits_a = '0; word_a = '0;
        repeat (3) tick();

        check_eq("rst_data_out", 64'(data_out), 64'd0);
        check_eq("rst_valid_out", 64'(valid_out), 64'd0);
        check_eq("rst_word_rdy", 64'(word_rdy), 64'd1);
        check_eq("rst_first_value", 64'(first_value), 64'd0);
        check_eq("rst_last_value", 64'(last_value), 64'd0);
        check_eq("rst_new_word_s", 64'(new_word_s), 64'd0);
        check_eq("rst_value_counter", 64'(value_counter), 64'd0);
        rst = 1'b0;
        tick();

        // Single word with flush, plus first-value latency.
        load_scn1();
        start_packet(0);
        write_all();
        k = 0;
        while (!valid_out && k < 20) begin
            tick();
            k++;
        end
        check_eq("latency", 64'(cyc - wr_cyc), 64'd2);
        drain_and_close("scn1", 1);

        // Residue carried across a word boundary, no flush.
        clear_words();
        add_word({10'b1010101010, 28'd0}, 10, 1'b1, 1'b0);
        add_word({4'b1100, 34'd0}, 4, 1'b0, 1'b1);
        start_packet(0);
        write_all();
        drain_and_close("carry", 2);

        // Backpressure with out_rdy pattern 1,0,0.
        load_scn1();
        hold_chk_en = 1'b1;
        start_packet(1);
        write_all();
        drain_and_close("bp", 1);
        hold_chk_en = 1'b0;

        // Buffer full: third write is dropped.
        clear_words();
        add_word(38'h3F_0123_4567, 38, 1'b1, 1'b0);
        add_word(38'h2A_5A5A_5A5A, 20, 1'b0, 1'b1);
        exp_q.delete();
        model_packet();
        rdy_mode = 2;
        n_pop = 0; xfer_cnt = 0; last_seen = 0;
        write_word(pw_data[0], pw_nb[0], 1'b1, 1'b0, 1'b0, a1);
        write_word(pw_data[1], pw_nb[1], 1'b0, 1'b1, 1'b0, a2);
        write_word(38'h3F_FFFF_FFFF, 38, 1'b0, 1'b1, 1'b0, a3);
        check_eq("full_acc1", 64'(a1), 64'd1);
        check_eq("full_acc2", 64'(a2), 64'd1);
        check_eq("full_acc3", 64'(a3), 64'd0);
        check_eq("full_word_rdy", 64'(word_rdy), 64'd0);
        rdy_mode = 0;
        packet_in_progress = 1'b1;
        drain_and_close("full", 2);

        // Abort after two transfers.
        load_scn1();
        start_packet(0);
        write_all();
        k = 0;
        while (xfer_cnt < 2 && k < 50) begin
            tick();
            k++;
        end
        check_eq("abort_reached", 64'(xfer_cnt >= 2), 64'd1);
        packet_in_progress = 1'b0;
        tick();
        check_eq("abort_valid", 64'(valid_out), 64'd0);
        check_eq("abort_counter", 64'(value_counter), 64'd0);
        check_eq("abort_word_rdy", 64'(word_rdy), 64'd1);
        check_eq("abort_first", 64'(first_value), 64'd0);
        check_eq("abort_no_last", 64'(last_seen), 64'd0);
        exp_q.delete();
        repeat (2) tick();
        check_eq("abort_idle_valid", 64'(valid_out), 64'd0);

        // Reset mid-packet, then the first scenario again.
        load_scn1();
        start_packet(2);
        write_all();
        k = 0;
        while (!valid_out && k < 20) begin
            tick();
            k++;
        end
        check_eq("rst_mid_valid", 64'(valid_out), 64'd1);
        rst = 1'b1;
        tick();
        check_eq("rst_mid_data", 64'(data_out), 64'd0);
        check_eq("rst_mid_valid_out", 64'(valid_out), 64'd0);
        check_eq("rst_mid_word_rdy", 64'(word_rdy), 64'd1);
        check_eq("rst_mid_flags", 64'({first_value, last_value, new_word_s}), 64'd0);
        check_eq("rst_mid_counter", 64'(value_counter), 64'd0);
        rst = 1'b0;
        packet_in_progress = 1'b0;
        exp_q.delete();
        tick();
        load_scn1();
        start_packet(0);
        write_all();
        drain_and_close("rerun", 1);

        check_eq("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
